delay_sweep_sched: RTL
======================

Name: delay_sweep_sched

Overview:
- Sequencer that steps the pulse generator's inter-pulse delay across a programmed sweep, without host round-trips per point.
- Latches sweep config on start, issues delay updates only at pulse-period boundaries, discards settling periods after each update, and counts averaged shots per point.
- Sits between host config registers and the pulse generator's delay/load inputs; runs on the generator's config clock domain.

Parameters:
DW, 16, width of delay value and counters
SETTLE, 1, periods discarded after each delay load (0 allowed)
DEF_DELAY, 200, reset value of delay output (cycles)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle sweep start request
abort  in  1  one-cycle sweep abort
cfg_delay0  in  DW  first-point delay (unsigned)
cfg_step  in  DW  per-point delay increment (two's complement, signed)
cfg_npts  in  DW  number of sweep points (0 treated as 1)
cfg_navg  in  DW  shots averaged per point (0 treated as 1)
period_end  in  1  one-cycle strobe from pulse generator at period wrap
delay  out  DW  delay value to pulse generator
load  out  1  one-cycle strobe: generator latches delay
shot_done  out  1  one-cycle strobe closing a counted (valid) shot
point_idx  out  DW  current point index, 0-based
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle strobe at sweep completion
range_err  out  1  sticky: delay clamped during this sweep

Behaviour:
- Reset (async, reset_n low): state IDLE; delay=DEF_DELAY; load=shot_done=done=busy=range_err=0; point_idx=0; internal counters 0.
- All outputs are registered. load, shot_done and done are exactly one cycle wide.
- States: IDLE, ARM, SETTLE, ACQ, DONE.
- IDLE:
  - start shadows all cfg_* values; cfg changes mid-sweep are ignored.
  - On start: delay<=cfg_delay0, point_idx<=0, range_err<=0, next state ARM.
  - A period_end in the same cycle as start is ignored.
- ARM: wait for the next period_end. At that period_end, load=1 in the following cycle. Next state is SETTLE (SETTLE>0) or ACQ (SETTLE=0).
- SETTLE:
  - Counts period_ends; the SETTLE-th one moves to ACQ.
  - No shot_done in this state.
- ACQ:
  - Each period_end produces shot_done the following cycle and increments avg_cnt.
  - On the period_end where avg_cnt==navg-1:
    - If point_idx==npts-1: go to DONE.
    - Otherwise: point_idx+1; delay<=delay+step; load next cycle; avg_cnt<=0; go to SETTLE/ACQ per SETTLE.
- Delay arithmetic:
  - Computed at DW+2 bits, signed.
  - Result <0 clamps to 0; result >2^DW-1 clamps to 2^DW-1. Either clamp sets range_err.
  - Clamped value is held for subsequent points and the sweep continues.
- DONE: done=1 for one cycle, coincident with the last shot_done; return to IDLE. delay holds its last value.
- load timing:
  - Asserted exactly one clk after the qualifying period_end.
  - delay is valid in the same cycle as load and stable until the next load.
- abort:
  - From any state, next state IDLE.
  - No load, shot_done or done is generated in that cycle or after.
  - delay and point_idx hold; range_err holds.
  - abort has priority over start and period_end in the same cycle.
- start outside IDLE is ignored.
- busy=0 in IDLE only; it deasserts the cycle after done.
- Back-to-back period_end on consecutive cycles is legal and each is counted.

Test Plan:
- Basic sweep: delay0=100, step=50, npts=3, navg=2, SETTLE=1, period_end every 20 clk.
  - load exactly 3 times, with delay 100, 150, 200.
  - shot_done 6 times; done one clk after the 10th period_end; busy low the next cycle; range_err=0.
- Clamp: delay0=10, step=-20 (0xFFEC), npts=3, navg=1.
  - delays 10, 0, 0; range_err=1 from the second load to the next start.
- Zero config: npts=0, navg=0, SETTLE=0.
  - One load (delay0) after the first period_end.
  - One shot_done and done after the second period_end.
- Abort in SETTLE of point 1 (delay0=100, step=50): abort the cycle after the 2nd load.
  - IDLE next clk, delay stays 150, point_idx=1.
  - No further load, shot_done or done over 5 subsequent period_ends.
- Collisions:
  - start+abort same cycle: stays IDLE, busy=0.
  - start+period_end same cycle: first load only at the following period_end.
  - start while busy: no effect on counts.
- Async reset mid-ACQ: reset_n low for 3 clk, asynchronous to clk edge.
  - All outputs at reset values immediately; delay=200.
  - A fresh start afterwards runs the basic sweep correctly.

Source files
------------

// File: rtl/delay_sweep_sched.sv
// Delay sweep sequencer: steps the pulse generator's inter-pulse delay across
// a programmed list of points, loading each new delay only at a period
// boundary, discarding settling periods and counting averaged shots.
//
// Handshake note: there is no backpressure anywhere. start, abort and
// period_end are single-cycle strobes sampled on every rising clk edge.
// load, shot_done and done are single-cycle registered strobes. delay is
// valid in the load cycle and holds until the next load.
module delay_sweep_sched #(
   parameter int unsigned DW        = 16,
   parameter int unsigned SETTLE    = 1,
   parameter int unsigned DEF_DELAY = 200
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] cfg_delay0,
   input  logic [DW-1:0] cfg_step,
   input  logic [DW-1:0] cfg_npts,
   input  logic [DW-1:0] cfg_navg,
   input  logic          period_end,
   output logic [DW-1:0] delay,
   output logic          load,
   output logic          shot_done,
   output logic [DW-1:0] point_idx,
   output logic          busy,
   output logic          done,
   output logic          range_err,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_SETTLE = 3'd2,
      S_ACQ    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // State entered after every delay load; settling is skipped entirely when SETTLE is 0.
   localparam state_t        POST_LOAD   = (SETTLE == 0) ? S_ACQ : S_SETTLE;
   localparam logic [DW-1:0] SETTLE_LAST = (SETTLE == 0) ? '0 : DW'(SETTLE - 1);

   state_t          state_q;
   logic [DW-1:0]   delay_q;
   logic [DW-1:0]   point_idx_q;
   logic [DW-1:0]   avg_cnt_q;
   logic [DW-1:0]   settle_cnt_q;
   logic [DW-1:0]   step_q;
   logic [DW-1:0]   npts_last_q;
   logic [DW-1:0]   navg_last_q;
   logic            load_q;
   logic            shot_q;
   logic            done_q;
   logic            busy_q;
   logic            range_err_q;

   logic signed [DW+1:0] sum_d;
   logic [DW-1:0]        next_delay_d;
   logic                 clamp_d;

   // Next point's delay: signed add with two guard bits, saturated to [0, 2^DW-1].
   always_comb begin
      sum_d        = $signed({2'b00, delay_q}) + $signed({{2{step_q[DW-1]}}, step_q});
      next_delay_d = sum_d[DW-1:0];
      clamp_d      = 1'b0;
      if (sum_d[DW+1]) begin
         next_delay_d = '0;
         clamp_d      = 1'b1;
      end else if (sum_d[DW]) begin
         next_delay_d = '1;
         clamp_d      = 1'b1;
      end
   end

   // Sweep FSM with registered strobes; abort overrides everything in its cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         delay_q      <= DW'(DEF_DELAY);
         point_idx_q  <= '0;
         avg_cnt_q    <= '0;
         settle_cnt_q <= '0;
         step_q       <= '0;
         npts_last_q  <= '0;
         navg_last_q  <= '0;
         load_q       <= 1'b0;
         shot_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         range_err_q  <= 1'b0;
      end else begin
         load_q <= 1'b0;
         shot_q <= 1'b0;
         done_q <= 1'b0;
         if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     step_q       <= cfg_step;
                     npts_last_q  <= (cfg_npts == '0) ? '0 : cfg_npts - DW'(1);
                     navg_last_q  <= (cfg_navg == '0) ? '0 : cfg_navg - DW'(1);
                     delay_q      <= cfg_delay0;
                     point_idx_q  <= '0;
                     range_err_q  <= 1'b0;
                     avg_cnt_q    <= '0;
                     settle_cnt_q <= '0;
                     busy_q       <= 1'b1;
                     state_q      <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (period_end) begin
                     load_q       <= 1'b1;
                     settle_cnt_q <= '0;
                     state_q      <= POST_LOAD;
                  end
               end
               S_SETTLE: begin
                  if (period_end) begin
                     if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        state_q      <= S_ACQ;
                     end else begin
                        settle_cnt_q <= settle_cnt_q + DW'(1);
                     end
                  end
               end
               S_ACQ: begin
                  if (period_end) begin
                     shot_q <= 1'b1;
                     if (avg_cnt_q == navg_last_q) begin
                        avg_cnt_q <= '0;
                        if (point_idx_q == npts_last_q) begin
                           done_q  <= 1'b1;
                           state_q <= S_DONE;
                        end else begin
                           point_idx_q  <= point_idx_q + DW'(1);
                           delay_q      <= next_delay_d;
                           range_err_q  <= range_err_q | clamp_d;
                           load_q       <= 1'b1;
                           settle_cnt_q <= '0;
                           state_q      <= POST_LOAD;
                        end
                     end else begin
                        avg_cnt_q <= avg_cnt_q + DW'(1);
                     end
                  end
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign delay     = delay_q;
   assign load      = load_q;
   assign shot_done = shot_q;
   assign point_idx = point_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;
   assign state_dbg = state_q;

endmodule
